// File: rtl/xmt_arbiter_seq.sv
// Shares one byte-serial transmitter among N_REQ requesters and sequences its load/ready/start strobes.
// Define XMT_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module xmt_arbiter_seq #(
  parameter int WORD_SIZE    = 8,
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = WORD_SIZE + 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [N_REQ-1:0]             i_req,
  input  logic [N_REQ*WORD_SIZE-1:0]   i_data,
  output logic [N_REQ-1:0]             o_ack,
  output logic                         o_busy,
  output logic [WORD_SIZE-1:0]         o_data_bus,
  output logic                         o_load_xmt_data,
  output logic                         o_byte_rdy,
  output logic                         o_T_byte
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(FRAME_CYCLES + 1);
  localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W+1)'(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RDY, S_START, S_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic [WORD_SIZE-1:0]   data_bus_q, data_bus_d;
  logic                   load_q, load_d;
  logic                   rdy_q, rdy_d;
  logic                   tbyte_q, tbyte_d;

  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W:0]         cand;

`ifdef XMT_ARB_ROUND_ROBIN_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  logic [IDX_W-1:0]       ptr_q, ptr_d;
`endif

  // Scan from the highest search offset down so the smallest offset is the last (winning) write.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef XMT_ARB_ROUND_ROBIN_EN
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
`else
      cand = (IDX_W+1)'(i);
`endif
      if (i_req[cand[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // NOTE: every signal driven here gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    data_bus_d = data_bus_q;
`ifdef XMT_ARB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          state_d            = S_LOAD;
          ack_d[grant_idx]   = 1'b1;
          data_bus_d         = i_data[grant_idx*WORD_SIZE +: WORD_SIZE];
`ifdef XMT_ARB_ROUND_ROBIN_EN
          ptr_d              = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
`endif
        end
      end
      S_LOAD:  state_d = S_RDY;
      S_RDY: begin
        state_d = S_START;
        cnt_d   = CNT_LOAD;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in the cycle they describe.
    busy_d  = (state_d != S_IDLE);
    load_d  = (state_d == S_LOAD);
    rdy_d   = (state_d == S_RDY);
    tbyte_d = (state_d == S_START);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      data_bus_q <= '0;
      load_q     <= 1'b0;
      rdy_q      <= 1'b0;
      tbyte_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      data_bus_q <= data_bus_d;
      load_q     <= load_d;
      rdy_q      <= rdy_d;
      tbyte_q    <= tbyte_d;
    end
  end

`ifdef XMT_ARB_ROUND_ROBIN_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

  assign o_ack           = ack_q;
  assign o_busy          = busy_q;
  assign o_data_bus      = data_bus_q;
  assign o_load_xmt_data = load_q;
  assign o_byte_rdy      = rdy_q;
  assign o_T_byte        = tbyte_q;

endmodule

// File: tb/tb_xmt_arbiter_seq.sv
// Scoreboard bench for xmt_arbiter_seq: a grant-level model predicts acks and per-frame strobe timing.
// Follows XMT_ARB_ROUND_ROBIN_EN to pick the expected arbitration policy.
module tb_xmt_arbiter_seq;

  localparam int WS      = 8;
  localparam int NR      = 4;
  localparam int FC      = WS + 2;
  localparam int SPACING = 4 + FC;
`ifdef XMT_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*WS-1:0]  data;
  logic [NR-1:0]     o_ack;
  logic              o_busy;
  logic [WS-1:0]     o_data_bus;
  logic              o_load;
  logic              o_byte_rdy;
  logic              o_T_byte;

  xmt_arbiter_seq #(.WORD_SIZE(WS), .N_REQ(NR), .FRAME_CYCLES(FC)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_req           (req),
    .i_data          (data),
    .o_ack           (o_ack),
    .o_busy          (o_busy),
    .o_data_bus      (o_data_bus),
    .o_load_xmt_data (o_load),
    .o_byte_rdy      (o_byte_rdy),
    .o_T_byte        (o_T_byte)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    int          idx;
    logic [WS-1:0] byte_v;
  } grant_t;

  grant_t        sb_q[$];
  grant_t        g_pop;
  int            n_cmp = 0;
  int            n_err = 0;
  int            edge_n = 0;
  int            last_g = -1000;
  int            free_at = 0;
  int            rr_ptr = 0;
  int            model_w;
  int            mon_d;
  logic [WS-1:0] exp_bus = '0;
  bit            auto_drop = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Policy rule: first requesting index found searching upward from p, wrapping modulo NR.
  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int off = 0; off < NR; off++) begin
      int k;
      k = (p + off) % NR;
      if (((r >> k) & 1) != 0) return k;
    end
    return -1;
  endfunction

  // Reference model: a grant may happen at any edge once the previous frame's spacing has elapsed.
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      last_g  = -1000;
      free_at = edge_n + 1;
      rr_ptr  = 0;
      exp_bus = '0;
      sb_q.delete();
    end else if (edge_n >= free_at && req != '0) begin
      model_w = pick(req, RR_EN ? rr_ptr : 0);
      exp_bus = data[model_w*WS +: WS];
      sb_q.push_back('{edge_no: edge_n, idx: model_w, byte_v: exp_bus});
      last_g  = edge_n;
      free_at = edge_n + SPACING;
      if (RR_EN) rr_ptr = (model_w + 1) % NR;
    end
  end

  // Monitor: per-cycle strobe/busy timing relative to the last grant, plus scoreboard pops on ack.
  always @(negedge clk) begin
    mon_d = edge_n - last_g;
    check("load_strobe", 64'(o_load),     64'(mon_d == 0));
    check("byte_rdy",    64'(o_byte_rdy), 64'(mon_d == 1));
    check("t_byte",      64'(o_T_byte),   64'(mon_d == 2));
    check("busy",        64'(o_busy),     64'(mon_d >= 0 && mon_d <= 2 + FC));
    check("data_bus",    64'(o_data_bus), 64'(exp_bus));
    if (o_ack != '0) begin
      if (sb_q.size() == 0) begin
        check("ack_unexpected", 64'(o_ack), 64'(0));
      end else begin
        g_pop = sb_q.pop_front();
        check("ack_vector", 64'(o_ack),      64'(1) << g_pop.idx);
        check("ack_edge",   64'(edge_n),     64'(g_pop.edge_no));
        check("ack_byte",   64'(o_data_bus), 64'(g_pop.byte_v));
      end
    end else if (sb_q.size() != 0 && sb_q[0].edge_no <= edge_n) begin
      check("ack_missing", 64'(o_ack), 64'(1) << sb_q[0].idx);
      void'(sb_q.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    if (auto_drop) req = req & ~o_ack;
  endtask

  task automatic wait_ack(input int k, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (o_ack[k]) return;
    end
    check("ack_timeout", 64'(o_ack), 64'(1) << k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({o_ack, o_busy, o_load, o_byte_rdy, o_T_byte, o_data_bus}), 64'(0));
    rst = 1'b0;
    idle(3);

    // Single request from requester 1.
    auto_drop = 1'b1;
    data[1*WS +: WS] = 8'hA5;
    req = 4'b0010;
    wait_ack(1, 10);
    idle(SPACING + 2);

    // All requesting, held.
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    auto_drop = 1'b0;
    req = 4'b1111;
    idle(5 * SPACING);
    req = '0;
    idle(SPACING);

    // Pointer wrap: last grant to 3, then 0 and 3 both pending.
    auto_drop = 1'b1;
    req = 4'b1000;
    wait_ack(3, 10);
    idle(SPACING);
    auto_drop = 1'b0;
    req = 4'b1001;
    idle(3 * SPACING);
    req = '0;
    idle(SPACING);

    // Late request arriving during WAIT.
    auto_drop = 1'b1;
    data[0 +: WS] = 8'h3C;
    data[2*WS +: WS] = 8'hC3;
    req = 4'b0001;
    wait_ack(0, 10);
    idle(6);
    req[2] = 1'b1;
    wait_ack(2, 2 * SPACING);
    idle(SPACING);

    // Request pulsed only during START is ignored.
    req = 4'b0001;
    wait_ack(0, 10);
    for (int i = 0; i < 6 && !o_T_byte; i++) tick();
    check("reached_start", 64'(o_T_byte), 64'(1));
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    idle(2 * SPACING);
    check("idle_after_withdraw", 64'(o_busy), 64'(0));

    // Reset during WAIT aborts the frame and clears the round-robin pointer.
    req = 4'b0100;
    wait_ack(2, 10);
    idle(5);
    #1 rst = 1'b1;
    #1 check("async_reset_outputs",
             64'({o_ack, o_busy, o_load, o_byte_rdy, o_T_byte, o_data_bus}), 64'(0));
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    check("busy_after_reset", 64'(o_busy), 64'(0));
    data[1*WS +: WS] = 8'h5A;
    data[3*WS +: WS] = 8'hE7;
    req = 4'b1010;
    idle(3 * SPACING);

    // Randomized traffic: requesters raise with fresh data and drop once acked.
    auto_drop = 1'b1;
    for (int c = 0; c < 900; c++) begin
      tick();
      for (int k = 0; k < NR; k++) begin
        if (!req[k] && $urandom_range(0, 9) == 0) begin
          data[k*WS +: WS] = WS'($urandom);
          req[k] = 1'b1;
        end
      end
    end
    req = '0;
    idle(2 * SPACING);
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
